// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC and the IF/ID pipeline register.
// The fetch address is driven straight from the PC register. Every other
// output is a register, so nothing else depends combinationally on an input.
// The PC register is updated in this priority order:
//   reset, then redirect, then stall, then PC + 4.
// The IF/ID register is updated in this priority order:
//   reset, then flush, then stall, then load.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;

    // The sequential PC adder wraps modulo 2^32 and raises no flag.
    // Redirect targets are word-aligned by clearing their low two bits.
    // A misaligned target therefore raises no exception.
    assign w_pc_plus4    = r_pc_f + 32'd4;
    assign w_redirect_pc = pc_target_e & 32'hFFFF_FFFC;

    // Fetch PC: a redirect beats stall_f, so a taken branch is never lost.
    always_ff @(posedge clk) begin
        if (rst)
            r_pc_f <= RESET_PC;
        else if (pc_src_e)
            r_pc_f <= w_redirect_pc;
        else if (!stall_f)
            r_pc_f <= w_pc_plus4;
    end

    // IF/ID register: flush beats stall and inserts a bubble.
    // This block never flushes itself. The hazard unit must assert flush_d
    // to drop the wrong-path word that was fetched while redirecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= 32'd0;
            r_pc_plus4_d  <= 32'd0;
            r_valid_d     <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (!stall_d) begin
            r_instr_d     <= imem_rdata;
            r_pc_d        <= r_pc_f;
            r_pc_plus4_d  <= w_pc_plus4;
            r_valid_d     <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc_f;
    assign instr_d     = r_instr_d;
    assign pc_d        = r_pc_d;
    assign pc_plus4_d  = r_pc_plus4_d;
    assign valid_d     = r_valid_d;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage.
// The instruction memory is modelled combinationally:
//   address 0 returns 32'h08802083,
//   any other address A returns {16'hC0DE, A[15:0]}.
// Inputs are driven on the falling edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0880_2083 : {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem(imem_addr);

    typedef struct {
        logic        rst, sf, sd, fl, ps;
        logic [31:0] tgt;
        logic [31:0] e_addr, e_instr, e_pc, e_p4;
        logic        e_v;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(
        input logic rs, sf, sd, fl, ps,
        input logic [31:0] tg, ea, ei, ep, e4,
        input logic ev,
        input logic [31:0] ec
    );
        vec_t v;
        v.rst = rs; v.sf = sf; v.sd = sd; v.fl = fl; v.ps = ps; v.tgt = tg;
        v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_p4 = e4;
        v.e_v = ev; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, ei, ep, e4,
                           input logic ev, input logic [31:0] ec);
        chk({tag, ".imem_addr"},   imem_addr,            ea);
        chk({tag, ".instr_d"},     instr_d,              ei);
        chk({tag, ".pc_d"},        pc_d,                 ep);
        chk({tag, ".pc_plus4_d"},  pc_plus4_d,           e4);
        chk({tag, ".valid_d"},     {31'd0, valid_d},     {31'd0, ev});
        chk({tag, ".fetch_count"}, fetch_count,          ec);
    endtask

    task automatic drive(input logic rs, sf, sd, fl, ps, input logic [31:0] tg);
        rst = rs; stall_f = sf; stall_d = sd; flush_d = fl;
        pc_src_e = ps; pc_target_e = tg;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // Table columns:
        //   rst sf sd fl ps | target | exp: addr instr pc_d pc+4 valid count
        vt[0]  = mk(1,0,0,0,0, 32'h0,   32'h0,   32'h13,        32'h0,   32'h0,   0, 0);
        // Reset wins over every other input.
        vt[1]  = mk(1,1,1,1,1, 32'h40,  32'h0,   32'h13,        32'h0,   32'h0,   0, 0);
        // Free run.
        vt[2]  = mk(0,0,0,0,0, 32'h0,   32'h4,   32'h08802083,  32'h0,   32'h4,   1, 1);
        vt[3]  = mk(0,0,0,0,0, 32'h0,   32'h8,   32'hC0DE0004,  32'h4,   32'h8,   1, 2);
        // Combined stall at pc_f = 8 for three cycles.
        vt[4]  = mk(0,1,1,0,0, 32'h0,   32'h8,   32'hC0DE0004,  32'h4,   32'h8,   1, 2);
        vt[5]  = mk(0,1,1,0,0, 32'h0,   32'h8,   32'hC0DE0004,  32'h4,   32'h8,   1, 2);
        vt[6]  = mk(0,1,1,0,0, 32'h0,   32'h8,   32'hC0DE0004,  32'h4,   32'h8,   1, 2);
        vt[7]  = mk(0,0,0,0,0, 32'h0,   32'hC,   32'hC0DE0008,  32'h8,   32'hC,   1, 3);
        vt[8]  = mk(0,0,0,0,0, 32'h0,   32'h10,  32'hC0DE000C,  32'hC,   32'h10,  1, 4);
        // Misaligned redirect together with a flush.
        vt[9]  = mk(0,0,0,1,1, 32'h3E,  32'h3C,  32'h13,        32'h0,   32'h0,   0, 4);
        vt[10] = mk(0,0,0,0,0, 32'h0,   32'h40,  32'hC0DE003C,  32'h3C,  32'h40,  1, 5);
        // Redirect beats stall_f, and flush beats stall_d.
        vt[11] = mk(0,1,1,1,1, 32'h101, 32'h100, 32'h13,        32'h0,   32'h0,   0, 5);
        // Redirect without a flush: the block does not flush itself.
        vt[12] = mk(0,0,0,0,1, 32'h202, 32'h200, 32'hC0DE0100, 32'h100, 32'h104, 1, 6);
        vt[13] = mk(0,0,0,0,0, 32'h0,   32'h204, 32'hC0DE0200, 32'h200, 32'h204, 1, 7);
        // stall_d alone holds IF/ID while the PC keeps advancing.
        vt[14] = mk(0,0,1,0,0, 32'h0,   32'h208, 32'hC0DE0200, 32'h200, 32'h204, 1, 7);
        // stall_f alone holds the PC while IF/ID keeps loading.
        vt[15] = mk(0,1,0,0,0, 32'h0,   32'h208, 32'hC0DE0208, 32'h208, 32'h20C, 1, 8);
        // Redirect to the top word, then wrap to address 0.
        vt[16] = mk(0,0,0,0,1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hC0DE0208, 32'h208, 32'h20C, 1, 9);
        vt[17] = mk(0,0,0,0,0, 32'h0,   32'h0,   32'hC0DEFFFC, 32'hFFFFFFFC, 32'h0, 1, 10);
        vt[18] = mk(0,0,0,0,0, 32'h0,   32'h4,   32'h08802083,  32'h0,   32'h4,   1, 11);
        // Redirect to 0x40, stall, then reset while still stalled.
        vt[19] = mk(0,0,0,0,1, 32'h40,  32'h40,  32'hC0DE0004,  32'h4,   32'h8,   1, 12);
        vt[20] = mk(0,1,1,0,0, 32'h0,   32'h40,  32'hC0DE0004,  32'h4,   32'h8,   1, 12);
        vt[21] = mk(1,1,1,0,0, 32'h0,   32'h0,   32'h13,        32'h0,   32'h0,   0, 0);
        vt[22] = mk(0,0,0,0,0, 32'h0,   32'h4,   32'h08802083,  32'h0,   32'h4,   1, 1);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].sf, vt[i].sd, vt[i].fl, vt[i].ps, vt[i].tgt);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_instr, vt[i].e_pc,
                    vt[i].e_p4, vt[i].e_v, vt[i].e_cnt);
        end

        // Long combined stall: the same fetch address is re-presented and
        // IF/ID stays frozen.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 1, 1, 0, 0, 0);
            @(posedge clk);
            #1;
            chk_all($sformatf("longstall%0d", i), 32'h4, 32'h08802083, 32'h0, 32'h4, 1, 1);
        end

        // Inputs changed mid-cycle must not ripple to any output.
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h80);
        #2;
        chk_all("comb_iso", 32'h4, 32'h08802083, 32'h0, 32'h4, 1, 1);
        @(posedge clk);
        #1;
        chk_all("redir_flush", 32'h80, 32'h13, 32'h0, 32'h0, 0, 1);

        // Reset arriving together with a redirect aborts the redirect.
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 32'h300);
        @(posedge clk);
        #1;
        chk_all("rst_redir", 32'h0, 32'h13, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("post_rst", 32'h4, 32'h08802083, 32'h0, 32'h4, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, bubble encoding (addi x0,x0,0) inserted into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall_f  input  1  hold fetch PC.
REQ-006 stall_d  input  1  hold IF/ID register.
REQ-007 flush_d  input  1  replace IF/ID contents with bubble.
REQ-008 pc_src_e  input  1  redirect request from execute (taken branch / JAL / JALR).
REQ-009 pc_target_e  input  32  redirect target address.
REQ-010 imem_addr  output  32  fetch address to instruction memory (current PC).
REQ-011 imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-012 instr_d  output  32  IF/ID instruction.
REQ-013 pc_d  output  32  IF/ID PC of instr_d.
REQ-014 pc_plus4_d  output  32  IF/ID pc_d + 4.
REQ-015 valid_d  output  1  IF/ID holds a real fetched instruction (0 = bubble).
REQ-016 fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-017 Internal register pc_f; imem_addr shall equal pc_f combinationally, no added latency.
REQ-018 Next-PC priority per edge: rst -> RESET_PC; else pc_src_e -> {pc_target_e[31:2],2'b00}; else stall_f -> hold; else pc_f + 4.
REQ-019 Redirect shall win over stall_f in the same cycle.
REQ-020 PC arithmetic shall be 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
REQ-021 Redirect target bits [1:0] shall be forced to 0; no misalignment exception is raised.
REQ-022 IF/ID update priority per edge: rst -> reset values; else flush_d -> bubble; else stall_d -> hold all IF/ID outputs and fetch_count; else load.
REQ-023 Load: instr_d <= imem_rdata, pc_d <= pc_f, pc_plus4_d <= pc_f + 4, valid_d <= 1, fetch_count <= fetch_count + 1.
REQ-024 Bubble: instr_d <= NOP_INSTR, pc_d <= 0, pc_plus4_d <= 0, valid_d <= 0, fetch_count unchanged.
REQ-025 flush_d shall win over stall_d when both are asserted.
REQ-026 Fetch latency: word at imem_addr = A in cycle N shall appear on instr_d with pc_d = A in cycle N+1 when not stalled or flushed.
REQ-027 Redirect in cycle N: the wrong-path word fetched in cycle N is removed only via flush_d; the block shall not self-flush.
REQ-028 Combined stall_f and stall_d shall re-present the same imem_addr and leave IF/ID unchanged for any number of cycles.
REQ-029 fetch_count shall wrap from 32'hFFFFFFFF to 0.
REQ-030 No output shall depend combinationally on any input except imem_addr on pc_f.
REQ-031 Debug $display of pc_f and loaded instruction per edge is permitted; it shall not affect synthesis behaviour.

Reset
REQ-032 While rst = 1 at an edge: pc_f = RESET_PC, instr_d = NOP_INSTR, pc_d = 0, pc_plus4_d = 0, valid_d = 0, fetch_count = 0, regardless of stall, flush and redirect inputs.
REQ-033 Reset asserted mid-stall or mid-redirect shall abort the operation; first fetch after deassertion is from RESET_PC.

Verification
REQ-034 Reset, then 4 free-run cycles with imem_rdata = 32'h08802083 at addr 0 -> imem_addr 0,4,8,C; instr_d = 32'h08802083, pc_d = 0, pc_plus4_d = 4 after first edge; fetch_count = 4.
REQ-035 stall_f = stall_d = 1 for 3 cycles at pc_f = 8 -> imem_addr stays 8; instr_d and pc_d = 4 unchanged; fetch_count unchanged.
REQ-036 pc_src_e = 1, pc_target_e = 32'h0000003E, flush_d = 1 same cycle -> next imem_addr = 32'h0000003C; instr_d = 32'h00000013, valid_d = 0.
REQ-037 pc_src_e = 1 with stall_f = 1 -> imem_addr takes target; flush_d = 1 with stall_d = 1 -> bubble loaded.
REQ-038 pc_f forced via redirect to 32'hFFFFFFFC, free-run -> next imem_addr = 0; pc_plus4_d = 0 for that fetch.
REQ-039 rst asserted during 2-cycle stall after redirect to 32'h40 -> next imem_addr = RESET_PC, all IF/ID outputs at reset values.
